// File: rtl/controle_entrada_pkg.sv
// Shared types and constants for the controle_entrada code-entry block.
package controle_entrada_pkg;

  // Access-control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    FAILED  = 2'd2,
    LOCKED  = 2'd3
  } estado_t;

  // Default accepted code, bit order {A,B,C}.
  localparam logic [2:0] SENHA_DEF = 3'b101;

  // Counter widths: debounce and lockout counters hold up to 255.
  localparam int DEB_CNT_W  = 8;
  localparam int LOCK_CNT_W = 8;
  localparam int TENT_W     = 2;

  // Failed-attempt increment that sticks at the all-ones value.
  function automatic logic [TENT_W-1:0] tent_inc_sat(input logic [TENT_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/controle_entrada_if.sv
// Code-entry bus: raw switch/button inputs, captured code and status outputs,
// plus debug visibility of the FSM state and debounced button level.
//
// Handshake: sw is level data and btn is its qualifier. A debounced rising
// edge of btn acts as "valid" and commits the synchronized sw value on the
// edge it is evaluated; there is no back-pressure (the block is always ready,
// except that commits are dropped while the lockout is active).
interface controle_entrada_if;
  import controle_entrada_pkg::*;

  logic [2:0] sw;
  logic       btn;
  logic       A;
  logic       B;
  logic       C;
  logic       ok;
  logic       erro;
  logic       bloqueado;
  logic [1:0] tentativas;
  estado_t    state_dbg;
  logic       btn_level;

  modport master (
    output sw, btn,
    input  A, B, C, ok, erro, bloqueado, tentativas, state_dbg, btn_level
  );

  modport slave (
    input  sw, btn,
    output A, B, C, ok, erro, bloqueado, tentativas, state_dbg, btn_level
  );

endinterface

// File: rtl/debounce_botao.sv
// Button conditioner: 2-flop synchronizer, then a level debouncer that needs
// DEB_CYCLES consecutive opposite samples to flip, and a one-cycle press
// pulse on each accepted rising level.
module debounce_botao
  import controle_entrada_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [DEB_CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/controle_entrada.sv
// Code-entry controller: captures a 3-bit code on each debounced button press,
// compares it to SENHA and reports grant/failure with an attempt counter.
// Optional lockout after MAX_TRIES failures is built when the macro
// CONTROLE_LOCKOUT_EN is defined; without it tentativas saturates at 3.
module controle_entrada
  import controle_entrada_pkg::*;
#(
  parameter int         DEB_CYCLES  = 4,
  parameter int         LOCK_CYCLES = 16,
  parameter int         MAX_TRIES   = 3,
  parameter logic [2:0] SENHA       = SENHA_DEF
) (
  input logic                clk,
  input logic                rst_n,
  controle_entrada_if.slave  bus
);

`ifdef CONTROLE_LOCKOUT_EN
  localparam logic LOCKOUT_ON = 1'b1;
`else
  localparam logic LOCKOUT_ON = 1'b0;
`endif

  localparam logic [TENT_W-1:0]     MAX_T     = TENT_W'(MAX_TRIES);
  localparam logic [LOCK_CNT_W-1:0] LOCK_LOAD = LOCK_CNT_W'(LOCK_CYCLES - 1);

  logic [2:0]            sw_s1;
  logic [2:0]            sw_s2;
  logic                  press;
  logic                  level;

  estado_t               state,    state_n;
  logic [2:0]            abc,      abc_n;
  logic                  ok,       ok_n;
  logic                  erro,     erro_n;
  logic                  bloq,     bloq_n;
  logic [TENT_W-1:0]     tent,     tent_n;
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_n;

  debounce_botao #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn),
    .level (level),
    .press (press)
  );

  // Per-bit 2-flop synchronizer for the code switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= 3'b000;
      sw_s2 <= 3'b000;
    end else begin
      sw_s1 <= bus.sw;
      sw_s2 <= sw_s1;
    end
  end

  // FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      abc      <= 3'b000;
      ok       <= 1'b0;
      erro     <= 1'b0;
      bloq     <= 1'b0;
      tent     <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      abc      <= abc_n;
      ok       <= ok_n;
      erro     <= erro_n;
      bloq     <= bloq_n;
      tent     <= tent_n;
      lock_cnt <= lock_n;
    end
  end

  // Next state: lockout countdown has priority over presses; otherwise a
  // press captures the code and grades it.
  always_comb begin
    state_n = state;
    abc_n   = abc;
    ok_n    = ok;
    erro_n  = erro;
    bloq_n  = bloq;
    tent_n  = tent;
    lock_n  = lock_cnt;
    if (state == LOCKED) begin
      if (lock_cnt == '0) begin
        state_n = IDLE;
        tent_n  = '0;
        bloq_n  = 1'b0;
        erro_n  = 1'b0;
        ok_n    = 1'b0;
      end else begin
        lock_n = lock_cnt - 1'b1;
      end
    end else if (press) begin
      abc_n = sw_s2;
      if (sw_s2 == SENHA) begin
        state_n = GRANTED;
        ok_n    = 1'b1;
        erro_n  = 1'b0;
        tent_n  = '0;
      end else begin
        ok_n   = 1'b0;
        erro_n = 1'b1;
        tent_n = tent_inc_sat(tent);
        if (LOCKOUT_ON && (tent_n == MAX_T)) begin
          state_n = LOCKED;
          bloq_n  = 1'b1;
          lock_n  = LOCK_LOAD;
        end else begin
          state_n = FAILED;
        end
      end
    end
  end

  assign bus.A          = abc[2];
  assign bus.B          = abc[1];
  assign bus.C          = abc[0];
  assign bus.ok         = ok;
  assign bus.erro       = erro;
  assign bus.bloqueado  = bloq;
  assign bus.tentativas = tent;
  assign bus.state_dbg  = state;
  assign bus.btn_level  = level;

endmodule

// File: tb/tb_controle_entrada.sv
// Bench for controle_entrada: an edge-level behavioural model predicts the
// outputs from the raw inputs (press times from run lengths of sampled btn,
// code from sw two edges back, lockout by absolute expiry edge).
module tb_controle_entrada;
  import controle_entrada_pkg::*;

  localparam int         DEB  = 4;
  localparam int         LOCK = 16;
  localparam int         MAXT = 3;
  localparam logic [2:0] CODE = 3'b101;
`ifdef CONTROLE_LOCKOUT_EN
  localparam logic LOCKOUT = 1'b1;
`else
  localparam logic LOCKOUT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  controle_entrada_if bus ();

  controle_entrada #(
    .DEB_CYCLES  (DEB),
    .LOCK_CYCLES (LOCK),
    .MAX_TRIES   (MAXT),
    .SENHA       (CODE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock.
  always #5 clk = ~clk;

  // Reference model state.
  int         m_t;
  int         m_run;
  logic       m_deb;
  int         due_q[$];
  logic [2:0] m_p1, m_p2;
  estado_t    m_state;
  logic [2:0] m_abc;
  logic       m_ok, m_erro, m_bloq;
  logic [1:0] m_tent;
  int         m_lock_end;

  task automatic model_clear();
    m_t = 0; m_run = 0; m_deb = 1'b0; due_q.delete();
    m_p1 = 3'b000; m_p2 = 3'b000; m_state = IDLE; m_abc = 3'b000;
    m_ok = 1'b0; m_erro = 1'b0; m_bloq = 1'b0; m_tent = 2'd0; m_lock_end = 0;
  endtask

  task automatic model_edge();
    logic       pr;
    logic [2:0] code;
    if (!rst_n) begin
      model_clear();
      return;
    end
    m_t++;
    pr = 1'b0;
    while (due_q.size() > 0 && due_q[0] == m_t) begin
      void'(due_q.pop_front());
      pr = 1'b1;
    end
    code = m_p2;
    m_p2 = m_p1;
    m_p1 = bus.sw;
    if (bus.btn != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = bus.btn;
        m_run = 0;
        if (m_deb) due_q.push_back(m_t + 3);
      end
    end else begin
      m_run = 0;
    end
    if (m_state == LOCKED) begin
      if (m_t == m_lock_end) begin
        m_state = IDLE; m_tent = 2'd0; m_bloq = 1'b0; m_erro = 1'b0; m_ok = 1'b0;
      end
    end else if (pr) begin
      m_abc = code;
      if (code == CODE) begin
        m_state = GRANTED; m_ok = 1'b1; m_erro = 1'b0; m_tent = 2'd0;
      end else begin
        m_ok = 1'b0; m_erro = 1'b1;
        if (m_tent != 2'd3) m_tent = m_tent + 2'd1;
        if (LOCKOUT && m_tent == 2'(MAXT)) begin
          m_state = LOCKED; m_bloq = 1'b1; m_lock_end = m_t + LOCK;
        end else begin
          m_state = FAILED;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  function automatic logic [7:0] obs_vec();
    return {bus.A, bus.B, bus.C, bus.ok, bus.erro, bus.bloqueado, bus.tentativas};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_abc, m_ok, m_erro, m_bloq, m_tent};
  endfunction

  // Driver: one press of the given code, 6 cycles high then 8 low.
  task automatic press_drive(input logic [2:0] code);
    bus.sw  = code;
    bus.btn = 1'b1;
    repeat (6) @(negedge clk);
    bus.btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.sw  = 3'b000;
    bus.btn = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== 8'h00 || bus.state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_hold got=%b/%0d exp=00000000/0", obs_vec(), bus.state_dbg);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== 8'h00 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_after_reset k=%0d got=%b exp=00000000", k, obs_vec());
      end
    end
  endtask

  task automatic test_grant();
    bus.sw  = 3'b101;
    bus.btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 12) bus.btn = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.state_dbg !== m_state) begin
        n_fail++;
        $display("FAIL grant_trace k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
      end
      if (k == 6) begin
        n_checks++;
        if (bus.ok !== 1'b0) begin
          n_fail++;
          $display("FAIL grant_early got=%b exp=0", bus.ok);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (obs_vec() !== 8'b101_1_0_0_00) begin
          n_fail++;
          $display("FAIL grant_edge7 got=%b exp=10110000", obs_vec());
        end
      end
    end
  endtask

  task automatic test_glitch();
    bus.sw = 3'b011;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        bus.btn = (k < 3);
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== 8'b101_1_0_0_00 || bus.btn_level !== 1'b0 || obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL glitch r=%0d k=%0d got=%b lvl=%b exp=10110000 lvl=0", r, k, obs_vec(), bus.btn_level);
        end
      end
    end
    bus.btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_lockout();
    bus.sw = 3'b011;
    for (int i = 1; i <= MAXT; i++) begin
      bus.btn = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 6) bus.btn = 1'b0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.state_dbg !== m_state) begin
          n_fail++;
          $display("FAIL lock_trace i=%0d k=%0d got=%b exp=%b", i, k, obs_vec(), exp_vec());
        end
      end
      n_checks++;
      if (bus.tentativas !== 2'(i)) begin
        n_fail++;
        $display("FAIL tent_count i=%0d got=%0d exp=%0d", i, bus.tentativas, i);
      end
    end
    n_checks++;
    if (bus.bloqueado !== LOCKOUT || bus.erro !== 1'b1 || bus.ok !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_entry got blq=%b erro=%b ok=%b exp blq=%b erro=1 ok=0", bus.bloqueado, bus.erro, bus.ok, LOCKOUT);
    end
    // Press with a different code while (possibly) locked.
    bus.sw  = 3'b110;
    bus.btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 6) bus.btn = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.state_dbg !== m_state) begin
        n_fail++;
        $display("FAIL lock_press_trace k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
      end
    end
    n_checks++;
`ifdef CONTROLE_LOCKOUT_EN
    if (obs_vec() !== 8'b011_0_0_0_00 || bus.state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL lock_expiry got=%b/%0d exp=01100000/0", obs_vec(), bus.state_dbg);
    end
`else
    if (obs_vec() !== 8'b110_0_1_0_11 || bus.state_dbg !== FAILED) begin
      n_fail++;
      $display("FAIL sat_after_fourth got=%b/%0d exp=11001011/2", obs_vec(), bus.state_dbg);
    end
`endif
  endtask

  task automatic test_recover();
    press_drive(3'b010);
    press_drive(3'b100);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.erro !== 1'b1) begin
      n_fail++;
      $display("FAIL recover_fails got=%b exp=%b", obs_vec(), exp_vec());
    end
    press_drive(3'b101);
    n_checks++;
    if (obs_vec() !== 8'b101_1_0_0_00 || bus.state_dbg !== GRANTED) begin
      n_fail++;
      $display("FAIL recover_grant got=%b exp=10110000", obs_vec());
    end
  endtask

`ifndef CONTROLE_LOCKOUT_EN
  task automatic test_saturate();
    for (int i = 1; i <= 5; i++) begin
      press_drive(3'b000);
      n_checks++;
      if (bus.tentativas !== ((i < 3) ? 2'(i) : 2'd3) || bus.bloqueado !== 1'b0) begin
        n_fail++;
        $display("FAIL saturate i=%0d got tent=%0d blq=%b exp tent=%0d blq=0", i, bus.tentativas, bus.bloqueado, (i < 3) ? i : 3);
      end
    end
  endtask
`endif

  task automatic test_random();
    int hi, lo;
    for (int it = 0; it < 40; it++) begin
      bus.sw = ($urandom_range(0, 3) == 0) ? CODE : 3'($urandom_range(0, 7));
      hi = $urandom_range(1, 8);
      lo = $urandom_range(1, 8);
      bus.btn = 1'b1;
      for (int k = 1; k <= hi + lo; k++) begin
        @(negedge clk);
        if (k == hi) bus.btn = 1'b0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.state_dbg !== m_state) begin
          n_fail++;
          $display("FAIL random it=%0d k=%0d got=%b/%0d exp=%b/%0d", it, k, obs_vec(), bus.state_dbg, exp_vec(), m_state);
        end
      end
    end
    bus.btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_async();
    repeat (LOCKOUT ? MAXT : 1) press_drive(3'b001);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.erro !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got=%b exp=%b", obs_vec(), exp_vec());
    end
    bus.sw  = 3'b101;
    bus.btn = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== 8'h00 || bus.state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL async_reset got=%b/%0d exp=00000000/0", obs_vec(), bus.state_dbg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset_trace k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
      end
      if (k == 6 || k == 7) begin
        n_checks++;
        if (bus.ok !== (k == 7)) begin
          n_fail++;
          $display("FAIL requalify k=%0d got ok=%b exp ok=%b", k, bus.ok, (k == 7));
        end
      end
    end
    bus.btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_grant();
    test_glitch();
    test_lockout();
    test_recover();
`ifndef CONTROLE_LOCKOUT_EN
    test_saturate();
`endif
    test_random();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_entrada.md
CONTROLE_ENTRADA -- requirements
Module: controle_entrada

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4; consecutive stable synchronized cycles required to accept a button level.
REQ-002 SHALL have parameter LOCK_CYCLES, default 16; lockout duration in clock cycles.
REQ-003 SHALL have parameter MAX_TRIES, default 3; failed attempts that trigger lockout (range 1..3).
REQ-004 SHALL have parameter SENHA, default 3'b101; accepted code, bit order {A,B,C}.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sw  in  3  raw code switches {A,B,C}, asynchronous to clk.
REQ-008 btn  in  1  raw confirm button, active-high, asynchronous, bouncing.
REQ-009 A, B, C  out  1 each  registered captured code, driving the downstream authentication display stage.
REQ-010 ok  out  1  access granted, level.
REQ-011 erro  out  1  last attempt failed, level.
REQ-012 bloqueado  out  1  lockout active.
REQ-013 tentativas  out  2  failed-attempt count.

Function
REQ-014 btn SHALL pass a 2-flop synchronizer; sw SHALL pass a 2-flop synchronizer per bit.
REQ-015 Debounced level SHALL change only after the synchronized btn holds the opposite value for DEB_CYCLES consecutive cycles; any mismatch restarts the count.
REQ-016 A rising edge of the debounced level SHALL produce a one-cycle press pulse; holding btn SHALL NOT produce further pulses.
REQ-017 FSM states: IDLE, GRANTED, FAILED, LOCKED.
REQ-018 On press outside LOCKED: A,B,C <= synchronized sw on the same edge; if {sw}==SENHA go GRANTED (ok=1, erro=0, tentativas=0), else FAILED (ok=0, erro=1, tentativas+1).
REQ-019 Outputs SHALL update on the edge 2+DEB_CYCLES+1 cycles after btn is first sampled high and stays high.
REQ-020 GRANTED and FAILED SHALL hold until the next press; a press from either state SHALL re-evaluate per REQ-018.
REQ-021 When a failed press makes tentativas equal MAX_TRIES, next state SHALL be LOCKED: bloqueado=1, erro=1, ok=0.
REQ-022 In LOCKED, presses SHALL be ignored and A,B,C frozen; a down-counter loaded with LOCK_CYCLES-1 SHALL decrement each cycle.
REQ-023 At counter zero: go IDLE, tentativas=0, bloqueado=0, erro=0, on that edge.
REQ-024 Press and lock expiry on the same edge: expiry wins, press discarded.
REQ-025 tentativas SHALL never exceed MAX_TRIES and SHALL never wrap.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, A=B=C=0, ok=0, erro=0, bloqueado=0, tentativas=0, synchronizers, debounce and lock counters to 0.
REQ-027 Reset mid-debounce or mid-lockout SHALL abort it; a button still held after release of reset SHALL require a full DEB_CYCLES qualification.
REQ-028 Reset deassertion SHALL take effect on the next rising edge of clk.

Configuration
REQ-029 Macro CONTROLE_LOCKOUT_EN: defined -> REQ-021..REQ-024 active; undefined -> LOCKED unreachable, bloqueado tied 0, tentativas saturates at 3, presses always evaluated.

Structure
REQ-030 Shared package SHALL hold the state enum, SENHA default, and counter width constants.
REQ-031 Synchronizer plus debounce SHALL be a sub-module debounce_botao (parameter DEB_CYCLES; outputs level and press pulse).

Verification
REQ-032 Reset release, no btn -> all outputs 0 indefinitely.
REQ-033 sw=101, clean press -> after 7 edges A,B,C=1,0,1, ok=1, tentativas=0.
REQ-034 btn glitches 3 cycles high, 1 low, repeated -> no press, outputs unchanged.
REQ-035 sw=011 pressed 3 times -> tentativas 1,2,3, then bloqueado=1; a press during lock ignored; after 16 cycles bloqueado=0, tentativas=0, state IDLE.
REQ-036 Two failures, then sw=101 press -> ok=1, erro=0, tentativas=0.
REQ-037 rst_n pulsed low mid-lockout -> outputs 0 asynchronously; without CONTROLE_LOCKOUT_EN, 5 failures -> tentativas=3, bloqueado=0.
